// File: rtl/branch_flag_unit.sv
// Flag register, conditional-branch resolution and fetch redirect for the ID stage.
// Define FLAG_FWD_EN to resolve branches on forwarded next-flags instead of stalling.
module branch_flag_unit #(
  parameter int AW   = 16,
  parameter int IMMW = 9
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  input  logic [3:0]      ex_opcode,
  input  logic [2:0]      ex_flag,
  input  logic            id_valid,
  input  logic [3:0]      id_opcode,
  input  logic [2:0]      id_ccc,
  input  logic [IMMW-1:0] id_imm,
  input  logic [AW-1:0]   id_pc,
  input  logic [AW-1:0]   id_rs,
  input  logic            redirect_ready,
  output logic [2:0]      flags,
  output logic            stall,
  output logic            redirect_valid,
  output logic [AW-1:0]   redirect_pc,
  output logic            flush
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT     = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  localparam logic [3:0] OP_B  = 4'b1100;
  localparam logic [3:0] OP_BR = 4'b1101;

  state_t          state_q;
  logic [2:0]      flags_q, flags_d;
  logic            stall_q;
  logic            redirect_valid_q;
  logic [AW-1:0]   redirect_pc_q;
  logic            flush_q;

  logic            upd_nvz, upd_z, sets_flag;
  logic [2:0]      eval_flags;
  logic            br, taken, hazard;
  logic [AW-1:0]   imm_ext, b_tgt, br_tgt, target;

  function automatic logic cond_met(input logic [2:0] ccc, input logic [2:0] f);
    logic n, v, z;
    n = f[2];
    v = f[1];
    z = f[0];
    case (ccc)
      3'b000:  cond_met = !z;
      3'b001:  cond_met = z;
      3'b010:  cond_met = !z && !n;
      3'b011:  cond_met = n;
      3'b100:  cond_met = z || !n;
      3'b101:  cond_met = n || z;
      3'b110:  cond_met = v;
      default: cond_met = 1'b1;
    endcase
  endfunction

  // ADD/SUB write all three flags; logical/shift ops write only Z.
  always_comb begin
    upd_nvz   = ex_valid && (ex_opcode == 4'b0000 || ex_opcode == 4'b0001);
    upd_z     = upd_nvz || (ex_valid && (ex_opcode == 4'b0011 || ex_opcode == 4'b0100 ||
                                         ex_opcode == 4'b0101 || ex_opcode == 4'b0110));
    sets_flag = upd_z;
    flags_d   = {upd_nvz ? ex_flag[2:1] : flags_q[2:1],
                 upd_z   ? ex_flag[0]   : flags_q[0]};
  end

`ifdef FLAG_FWD_EN
  assign eval_flags = flags_d;
  assign hazard     = 1'b0;
`else
  assign eval_flags = flags_q;
  assign hazard     = br && (id_ccc != 3'b111) && sets_flag;
`endif

  assign br    = id_valid && (id_opcode == OP_B || id_opcode == OP_BR);
  assign taken = cond_met(id_ccc, eval_flags);

  always_comb begin
    imm_ext = {{(AW-IMMW){id_imm[IMMW-1]}}, id_imm};
    b_tgt   = id_pc + AW'(2) + {imm_ext[AW-2:0], 1'b0};
    br_tgt  = {id_rs[AW-1:1], 1'b0};
    target  = (id_opcode == OP_BR) ? br_tgt : b_tgt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= 3'b000;
    end else begin
      flags_q <= flags_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      stall_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      flush_q          <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (br && hazard) begin
            state_q <= WAIT;
            stall_q <= 1'b1;
          end else if (br && taken) begin
            state_q          <= REDIRECT;
            redirect_pc_q    <= target;
            redirect_valid_q <= 1'b1;
            flush_q          <= 1'b1;
            stall_q          <= 1'b1;
          end
        end
        // Flags committed on the edge into this state; re-resolve next cycle.
        WAIT: begin
          state_q <= IDLE;
          stall_q <= 1'b0;
        end
        REDIRECT: begin
          if (redirect_ready) begin
            state_q          <= IDLE;
            redirect_valid_q <= 1'b0;
            flush_q          <= 1'b0;
            stall_q          <= 1'b0;
          end
        end
        default: begin
          state_q          <= IDLE;
          stall_q          <= 1'b0;
          redirect_valid_q <= 1'b0;
          flush_q          <= 1'b0;
        end
      endcase
    end
  end

  assign flags          = flags_q;
  assign stall          = stall_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign flush          = flush_q;

endmodule

// File: tb/tb_branch_flag_unit.sv
// Directed bench for branch_flag_unit: expected redirect targets are queued at issue
// and checked by a monitor on the redirect handshake; flags/stall checked inline.
module tb_branch_flag_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic [3:0]  ex_opcode;
  logic [2:0]  ex_flag;
  logic        id_valid;
  logic [3:0]  id_opcode;
  logic [2:0]  id_ccc;
  logic [8:0]  id_imm;
  logic [15:0] id_pc;
  logic [15:0] id_rs;
  logic        redirect_ready;
  logic [2:0]  flags;
  logic        stall;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        flush;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_q[$];

  branch_flag_unit #(.AW(16), .IMMW(9)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_flag(ex_flag),
    .id_valid(id_valid), .id_opcode(id_opcode), .id_ccc(id_ccc),
    .id_imm(id_imm), .id_pc(id_pc), .id_rs(id_rs),
    .redirect_ready(redirect_ready),
    .flags(flags), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .flush(flush)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ex_set(input logic v, input logic [3:0] op, input logic [2:0] f);
    ex_valid  = v;
    ex_opcode = op;
    ex_flag   = f;
  endtask

  task automatic id_set(input logic v, input logic [3:0] op, input logic [2:0] ccc,
                        input logic [8:0] imm, input logic [15:0] pc, input logic [15:0] rs);
    id_valid  = v;
    id_opcode = op;
    id_ccc    = ccc;
    id_imm    = imm;
    id_pc     = pc;
    id_rs     = rs;
  endtask

  // Redirect monitor: stable while stalled on ready, popped on handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && redirect_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_redirect", {16'h0, redirect_pc}, 32'hFFFF_FFFF);
        end else if (redirect_ready) begin
          check("redirect_pc_accept", {16'h0, redirect_pc}, {16'h0, exp_q[0]});
          check("redirect_flush", {31'h0, flush}, 32'h1);
          void'(exp_q.pop_front());
        end else begin
          check("redirect_pc_hold", {16'h0, redirect_pc}, {16'h0, exp_q[0]});
        end
      end
    end
  end

  initial begin
    rst_n          = 1'b0;
    redirect_ready = 1'b0;
    ex_set(1'b0, 4'h0, 3'b000);
    id_set(1'b0, 4'h0, 3'b000, 9'h0, 16'h0, 16'h0);
    tick();
    tick();
    check("rst_flags", {29'h0, flags}, 32'h0);
    check("rst_stall", {31'h0, stall}, 32'h0);
    check("rst_rvalid", {31'h0, redirect_valid}, 32'h0);
    check("rst_rpc", {16'h0, redirect_pc}, 32'h0);
    check("rst_flush", {31'h0, flush}, 32'h0);
    rst_n = 1'b1;
    tick();

    // Commit mask
    ex_set(1'b1, 4'b0001, 3'b101);
    tick();
    check("sub_flags", {29'h0, flags}, 32'h5);
    ex_set(1'b1, 4'b0011, 3'b000);
    tick();
    check("xor_flags", {29'h0, flags}, 32'h4);
    ex_set(1'b1, 4'b1000, 3'b001);
    tick();
    check("paddsb_flags", {29'h0, flags}, 32'h4);
    ex_set(1'b1, 4'b0000, 3'b001);
    tick();
    check("add_flags_z", {29'h0, flags}, 32'h1);
    ex_set(1'b0, 4'h0, 3'b000);

    // Taken B, EQ, pc=0x10 imm=-3 -> 0x000C, with ready held off
    id_set(1'b1, 4'b1100, 3'b001, 9'h1FD, 16'h0010, 16'h0);
    exp_q.push_back(16'h000C);
    check("b_pre_stall", {31'h0, stall}, 32'h0);
    tick();
    id_set(1'b0, 4'h0, 3'b000, 9'h0, 16'h0, 16'h0);
    check("b_rvalid", {31'h0, redirect_valid}, 32'h1);
    check("b_rpc", {16'h0, redirect_pc}, 32'h000C);
    check("b_flush", {31'h0, flush}, 32'h1);
    check("b_stall", {31'h0, stall}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("b_hold_rvalid", {31'h0, redirect_valid}, 32'h1);
    end
    redirect_ready = 1'b1;
    tick();
    redirect_ready = 1'b0;
    check("b_done_rvalid", {31'h0, redirect_valid}, 32'h0);
    check("b_done_flush", {31'h0, flush}, 32'h0);

    // Clear Z, then hazard: ADD sets Z while B EQ is in ID
    ex_set(1'b1, 4'b0000, 3'b000);
    tick();
    check("clr_flags", {29'h0, flags}, 32'h0);
    ex_set(1'b1, 4'b0000, 3'b001);
    id_set(1'b1, 4'b1100, 3'b001, 9'd4, 16'h0100, 16'h0);
    exp_q.push_back(16'h010A);
    tick();
    ex_set(1'b0, 4'h0, 3'b000);
    check("hz_flags", {29'h0, flags}, 32'h1);
`ifdef FLAG_FWD_EN
    id_set(1'b0, 4'h0, 3'b000, 9'h0, 16'h0, 16'h0);
    check("hz_fwd_rvalid", {31'h0, redirect_valid}, 32'h1);
    check("hz_fwd_rpc", {16'h0, redirect_pc}, 32'h010A);
`else
    check("hz_stall", {31'h0, stall}, 32'h1);
    check("hz_wait_rvalid", {31'h0, redirect_valid}, 32'h0);
    tick();
    check("hz_stall_drop", {31'h0, stall}, 32'h0);
    check("hz_idle_rvalid", {31'h0, redirect_valid}, 32'h0);
    tick();
    id_set(1'b0, 4'h0, 3'b000, 9'h0, 16'h0, 16'h0);
    check("hz_rvalid", {31'h0, redirect_valid}, 32'h1);
    check("hz_rpc", {16'h0, redirect_pc}, 32'h010A);
`endif
    redirect_ready = 1'b1;
    tick();
    redirect_ready = 1'b0;

    // BR with ccc=111 while SUB in EX: no flag wait
    ex_set(1'b1, 4'b0001, 3'b100);
    id_set(1'b1, 4'b1101, 3'b111, 9'h0, 16'h0300, 16'h1235);
    exp_q.push_back(16'h1234);
    tick();
    ex_set(1'b0, 4'h0, 3'b000);
    id_set(1'b0, 4'h0, 3'b000, 9'h0, 16'h0, 16'h0);
    check("br_rvalid", {31'h0, redirect_valid}, 32'h1);
    check("br_rpc", {16'h0, redirect_pc}, 32'h1234);
    check("br_flags", {29'h0, flags}, 32'h4);
    redirect_ready = 1'b1;
    tick();
    redirect_ready = 1'b0;

    // Not taken: OV with V=0
    id_set(1'b1, 4'b1100, 3'b110, 9'd8, 16'h0200, 16'h0);
    tick();
    id_set(1'b0, 4'h0, 3'b000, 9'h0, 16'h0, 16'h0);
    check("nt_rvalid", {31'h0, redirect_valid}, 32'h0);
    check("nt_stall", {31'h0, stall}, 32'h0);
    tick();
    check("nt_rvalid2", {31'h0, redirect_valid}, 32'h0);

    // Target wrap 0xFFFE + 2 + 2 -> 0x0002, then reset mid-REDIRECT
    id_set(1'b1, 4'b1100, 3'b111, 9'd1, 16'hFFFE, 16'h0);
    exp_q.push_back(16'h0002);
    tick();
    id_set(1'b0, 4'h0, 3'b000, 9'h0, 16'h0, 16'h0);
    check("wrap_rvalid", {31'h0, redirect_valid}, 32'h1);
    check("wrap_rpc", {16'h0, redirect_pc}, 32'h0002);
    tick();
    rst_n = 1'b0;
    #1;
    check("amid_rvalid", {31'h0, redirect_valid}, 32'h0);
    check("amid_stall", {31'h0, stall}, 32'h0);
    check("amid_flags", {29'h0, flags}, 32'h0);
    check("amid_flush", {31'h0, flush}, 32'h0);
    exp_q.delete();
    redirect_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_rvalid", {31'h0, redirect_valid}, 32'h0);
    end
    redirect_ready = 1'b0;
    tick();
    check("queue_drained", exp_q.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_flag_unit.md
Name: branch_flag_unit

Overview:
- Consumer end of the ALU flag interface.
- Holds the architectural N/V/Z flag register, committing the 3-bit ALU flags when a flag-setting EX instruction retires.
- Resolves conditional branches (B, BR) in ID against those flags, computes the branch target, and issues a redirect to fetch under a valid/ready handshake.
- Generates ID stall and IF/ID flush.

Parameters:
- AW, 16, PC/target width
- IMMW, 9, branch immediate width (signed, halfword units)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ex_valid  in  1  EX holds a valid instruction that advances this cycle
- ex_opcode  in  4  opcode of the EX instruction
- ex_flag  in  3  ALU flags {N,V,Z}, bit2=N, bit1=V, bit0=Z
- id_valid  in  1  ID holds a valid instruction
- id_opcode  in  4  ID opcode; 1100=B, 1101=BR, others ignored
- id_ccc  in  3  branch condition code
- id_imm  in  IMMW  signed branch offset
- id_pc  in  AW  address of the ID instruction
- id_rs  in  AW  register target for BR
- redirect_ready  in  1  fetch accepts redirect
- flags  out  3  architectural {N,V,Z}
- stall  out  1  hold PC and IF/ID, inject bubble into EX
- redirect_valid  out  1  redirect request
- redirect_pc  out  AW  redirect target
- flush  out  1  kill IF/ID contents

Behaviour:
- Reset (async, rst_n=0): flags=000, state=IDLE, redirect_valid=0, redirect_pc=0, stall=0, flush=0. Reset mid-REDIRECT drops the request immediately.
- Flag commit on rising edge when ex_valid=1, masked by ex_opcode:
  - 0000, 0001 (ADD/SUB): update N,V,Z.
  - 0011, 0100, 0101, 0110 (XOR/SLL/SRA/ROR): update Z only.
  - All other opcodes: no update.
- setsflag(op) = op is in either update set above.
- Condition evaluation (cond):
  - 000 NE: Z=0
  - 001 EQ: Z=1
  - 010 GT: Z=0 and N=0
  - 011 LT: N=1
  - 100 GE: Z=1, or (Z=0 and N=0)
  - 101 LE: N=1 or Z=1
  - 110 OV: V=1
  - 111: always taken
- Targets (16-bit wrap, no overflow detect):
  - B: id_pc + 2 + (sext(id_imm) << 1)
  - BR: id_rs & 16'hFFFE
- br = id_valid & (id_opcode==1100 | id_opcode==1101).
- hazard = br & ccc!=111 & ex_valid & setsflag(ex_opcode).
- FSM states: IDLE, WAIT, REDIRECT.
  - IDLE, br & hazard: stall=1, go to WAIT.
  - IDLE, br & !hazard & taken: register target into redirect_pc, go to REDIRECT; stall=0 (branch retires).
  - IDLE, br & !hazard & not taken: stay IDLE, no stall.
  - IDLE, non-branch or id_valid=0: no action.
  - WAIT: stall=1 for exactly one cycle while flags commit on its edge, then IDLE. The branch is still in ID and is re-evaluated; EX now holds a bubble, so no hazard.
  - REDIRECT: redirect_valid=1, flush=1, stall=1, redirect_pc held stable until redirect_ready=1. On the ready edge go to IDLE; redirect_valid falls the next cycle.
- Redirect latency: redirect_valid rises one cycle after the taken branch is resolved.
- Flags keep updating in every state.
- ccc=111 never stalls on flags.

Optional Feature:
- Macro FLAG_FWD_EN.
- Defined: evaluation uses forwarded next-flags, i.e. ex_flag merged through the commit mask when ex_valid=1. hazard is forced to 0 and the WAIT state is unreachable.
- Undefined: evaluation uses the flag register only, with the WAIT stall as described.
- Flag register contents are identical in both builds.

Test Plan:
- Reset: hold rst_n=0 mid-REDIRECT, then release -> flags=000, redirect_valid=0, stall=0 immediately, no redirect emitted after release.
- Commit mask: SUB producing flag=101 -> flags=101. Then XOR with flag=000 -> flags=100 (N kept). Then PADDSB with flag=001 -> flags unchanged at 100.
- Taken B with ccc=001, Z=1, id_pc=0x0010, imm=-3 -> next cycle redirect_valid=1, redirect_pc=0x000C, flush=1. Hold redirect_ready=0 for 3 cycles -> request stays stable. Ready=1 -> IDLE.
- Hazard (macro off): ADD in EX yields Z=1 while B with ccc=001 is in ID and flags.Z=0 -> stall=1 for 1 cycle, then taken. With FLAG_FWD_EN -> no stall, taken the same cycle.
- BR with id_rs=0x1235 and ccc=111 while SUB is in EX -> no stall, redirect_pc=0x1234.
- Not taken: ccc=110 with V=0 -> no redirect, no stall. Target wrap: id_pc=0xFFFE, imm=+1, ccc=111 -> redirect_pc=0x0002.
